vdu_writer: RTL

- Write-side controller for the VDU-80 character memory.
- Accepts CPU-side character writes plus two commands (clear screen, scroll up one row), and turns them into dual-port VRAM write cycles (char byte + attribute byte).
- Owns the 5-bit scroll counter consumed by the display path (`i_counter` / `i_counter_valid`).
- Sits between the Z80 port/memory decode and the VRAM write port; the display reads the other VRAM port.

---
 rtl/vdu_writer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/vdu_writer.sv
// VDU-80 character memory write controller: cell writes, clear and scroll.
// Optional `VDU_WRITER_FILL_EN adds run-time fill char/attr inputs.
module vdu_writer #(
    parameter int          ROWS     = 24,
    parameter int          COLS     = 80,
    parameter logic [7:0]  CLR_CHAR = 8'h20,
    parameter logic [7:0]  CLR_ATTR = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_valid,
    input  logic [4:0]  i_wr_row,
    input  logic [6:0]  i_wr_col,
    input  logic [7:0]  i_wr_char,
    input  logic [7:0]  i_wr_attr,
`ifdef VDU_WRITER_FILL_EN
    input  logic [7:0]  i_fill_char,
    input  logic [7:0]  i_fill_attr,
`endif
    input  logic        i_clr_valid,
    input  logic        i_scroll_valid,
    output logic        o_ready,
    output logic        o_vram_we,
    output logic [10:0] o_vram_addr,
    output logic [7:0]  o_vram_char,
    output logic [7:0]  o_vram_attr,
    output logic [4:0]  o_counter,
    output logic        o_counter_valid
);

    localparam logic [5:0]  ROWS_W  = 6'(ROWS);
    localparam logic [6:0]  COLS_W  = 7'(COLS);
    localparam logic [4:0]  LAST_RW = 5'(ROWS - 1);
    localparam logic [10:0] CELLS   = 11'(ROWS * COLS);
    localparam logic [10:0] ROW_LEN = 11'(COLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_CLEAR_ALL,
        S_CLEAR_ROW,
        S_UPDATE
    } state_e;

    state_e      state_q, state_d;
    logic        ready_q, ready_d;
    logic        we_q, we_d;
    logic [10:0] addr_q, addr_d;
    logic [7:0]  char_q, char_d;
    logic [7:0]  attr_q, attr_d;
    logic [4:0]  counter_q, counter_d;
    logic        cv_q, cv_d;
    logic [10:0] idx_q, idx_d;
    logic [10:0] base_q, base_d;

    logic [7:0]  fill_char;
    logic [7:0]  fill_attr;
    logic [5:0]  row_sum;
    logic [4:0]  phys_row;
    logic [10:0] wr_addr;
    logic        wr_ok;
    logic [4:0]  next_cnt;

`ifdef VDU_WRITER_FILL_EN
    assign fill_char = i_fill_char;
    assign fill_attr = i_fill_attr;
`else
    assign fill_char = CLR_CHAR;
    assign fill_attr = CLR_ATTR;
`endif

    // row * 80 as (r<<6)+(r<<4), 11 bits wide
    function automatic logic [10:0] row_base(input logic [4:0] r);
        return {r, 6'b0} + {2'b0, r, 4'b0};
    endfunction

    assign row_sum  = {1'b0, i_wr_row} + {1'b0, counter_q};
    assign phys_row = (row_sum >= ROWS_W) ? 5'(row_sum - ROWS_W)
                                          : row_sum[4:0];
    assign wr_addr  = row_base(phys_row) + {4'b0, i_wr_col};
    assign wr_ok    = ({1'b0, i_wr_row} < ROWS_W) && (i_wr_col < COLS_W);
    assign next_cnt = (counter_q == LAST_RW) ? 5'd0 : counter_q + 5'd1;

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        char_d    = char_q;
        attr_d    = attr_q;
        counter_d = counter_q;
        cv_d      = 1'b0;
        idx_d     = idx_q;
        base_d    = base_q;
        unique case (state_q)
            S_IDLE, S_UPDATE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                if (i_clr_valid) begin
                    state_d = S_CLEAR_ALL;
                    ready_d = 1'b0;
                    we_d    = 1'b1;
                    addr_d  = 11'd0;
                    idx_d   = 11'd1;
                    char_d  = fill_char;
                    attr_d  = fill_attr;
                end else if (i_scroll_valid) begin
                    state_d = S_CLEAR_ROW;
                    ready_d = 1'b0;
                    we_d    = 1'b1;
                    base_d  = row_base(counter_q);
                    addr_d  = row_base(counter_q);
                    idx_d   = 11'd1;
                    char_d  = fill_char;
                    attr_d  = fill_attr;
                end else if (i_wr_valid) begin
                    state_d = S_WRITE;
                    ready_d = 1'b0;
                    we_d    = wr_ok;
                    addr_d  = wr_addr;
                    char_d  = i_wr_char;
                    attr_d  = i_wr_attr;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            S_CLEAR_ALL: begin
                if (idx_q == CELLS) begin
                    state_d   = S_UPDATE;
                    ready_d   = 1'b1;
                    counter_d = 5'd0;
                    cv_d      = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    addr_d = idx_q;
                    idx_d  = idx_q + 11'd1;
                end
            end
            S_CLEAR_ROW: begin
                // the wiped row was logical row 0 and becomes logical row 23
                if (idx_q == ROW_LEN) begin
                    state_d   = S_UPDATE;
                    ready_d   = 1'b1;
                    counter_d = next_cnt;
                    cv_d      = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    addr_d = base_q + idx_q;
                    idx_d  = idx_q + 11'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= 11'd0;
            char_q    <= 8'd0;
            attr_q    <= 8'd0;
            counter_q <= 5'd0;
            cv_q      <= 1'b0;
            idx_q     <= 11'd0;
            base_q    <= 11'd0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            char_q    <= char_d;
            attr_q    <= attr_d;
            counter_q <= counter_d;
            cv_q      <= cv_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
        end
    end

    assign o_ready         = ready_q;
    assign o_vram_we       = we_q;
    assign o_vram_addr     = addr_q;
    assign o_vram_char     = char_q;
    assign o_vram_attr     = attr_q;
    assign o_counter       = counter_q;
    assign o_counter_valid = cv_q;

endmodule
